// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module : store_buffer
// Circular store FIFO between the Memory stage and dmem with youngest-match
// store-to-load forwarding.
// Rev    : 1.0
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWriteM,
  input  logic                   MemReadM,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  output logic                   StallSB,
  output logic                   FwdHitM,
  output logic [31:0]            FwdDataM,
  output logic                   MemWE,
  output logic [31:0]            MemAdr,
  output logic [31:0]            MemWD,
  input  logic                   MemReady,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]      addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    head_ptr;
  logic [AW-1:0]    tail_ptr;
  logic [AW:0]      cnt;
  logic [AW-1:0]    idx;
  logic             full;
  logic             enq;
  logic             deq;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign Empty   = (cnt == '0);
  assign enq     = MemWriteM & ~full;
  assign deq     = ~Empty & MemReady;
  assign StallSB = MemWriteM & full;
  assign MemWE   = ~Empty;
  assign MemAdr  = Empty ? '0 : addr_mem[head_ptr];
  assign MemWD   = Empty ? '0 : data_mem[head_ptr];
  assign Count   = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
      valid    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      // head and tail never coincide when both enq and deq fire, so the
      // valid clear and set below never target the same slot
      if (deq) begin
        valid[head_ptr] <= 1'b0;
        head_ptr        <= head_ptr + AW'(1);
      end
      if (enq) begin
        addr_mem[tail_ptr] <= ALUResultM;
        data_mem[tail_ptr] <= WriteDataM;
        valid[tail_ptr]    <= 1'b1;
        tail_ptr           <= tail_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    FwdHitM  = 1'b0;
    FwdDataM = '0;
    idx      = head_ptr;
    if (MemReadM) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_ptr + AW'(k);
        if (valid[idx] && (addr_mem[idx][31:2] == ALUResultM[31:2])) begin
          FwdHitM  = 1'b1;
          FwdDataM = data_mem[idx];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_store_buffer
// Directed and random stimulus for store_buffer against a queue-based model.
// Rev    : 1.0
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWriteM;
  logic          MemReadM;
  logic [31:0]   ALUResultM;
  logic [31:0]   WriteDataM;
  logic          MemReady;
  logic          StallSB;
  logic          FwdHitM;
  logic [31:0]   FwdDataM;
  logic          MemWE;
  logic [31:0]   MemAdr;
  logic [31:0]   MemWD;
  logic          Empty;
  logic [CW-1:0] Count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          drained  = 0;
  logic [63:0] model_q[$];
  logic [31:0] saved_addr;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallSB    (StallSB),
    .FwdHitM    (FwdHitM),
    .FwdDataM   (FwdDataM),
    .MemWE      (MemWE),
    .MemAdr     (MemAdr),
    .MemWD      (MemWD),
    .MemReady   (MemReady),
    .Empty      (Empty),
    .Count      (Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected outputs come from the queue: front = head, back = youngest.
  task automatic check_all(input logic we, input logic re, input logic [31:0] addr);
    logic        hit;
    logic [31:0] fdata;
    int          n;
    n     = model_q.size();
    hit   = 1'b0;
    fdata = '0;
    if (re) begin
      for (int i = 0; i < n; i++) begin
        if (model_q[i][63:34] == addr[31:2]) begin
          hit   = 1'b1;
          fdata = model_q[i][31:0];
        end
      end
    end
    chk("Count",    32'(Count),   32'(n));
    chk("Empty",    32'(Empty),   32'(n == 0));
    chk("MemWE",    32'(MemWE),   32'(n != 0));
    chk("MemAdr",   MemAdr,       (n != 0) ? model_q[0][63:32] : 32'h0);
    chk("MemWD",    MemWD,        (n != 0) ? model_q[0][31:0]  : 32'h0);
    chk("StallSB",  32'(StallSB), 32'(we && (n == DEPTH)));
    chk("FwdHitM",  32'(FwdHitM), 32'(hit));
    chk("FwdDataM", FwdDataM,     fdata);
  endtask

  task automatic cycle(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] data, input logic rdy);
    int n;
    MemWriteM  = we;
    MemReadM   = re;
    ALUResultM = addr;
    WriteDataM = data;
    MemReady   = rdy;
    #2;
    check_all(we, re, addr);
    n = model_q.size();
    @(posedge clk);
    if (n != 0 && rdy) begin
      void'(model_q.pop_front());
      drained++;
    end
    if (we && n < DEPTH) model_q.push_back({addr, data});
    #1;
  endtask

  task automatic drain_all();
    for (int k = 0; k < DEPTH + 2 && model_q.size() != 0; k++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("drain_empty", 32'(Empty), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; MemWriteM = 1'b0; MemReadM = 1'b0;
    ALUResultM = '0; WriteDataM = '0; MemReady = 1'b0;
    #1;
    check_all(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // basic store and drain
    cycle(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1);
    chk("basic_we",  32'(MemWE), 32'h1);
    chk("basic_adr", MemAdr,     32'h100);
    chk("basic_wd",  MemWD,      32'hDEADBEEF);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("basic_empty", 32'(Empty), 32'h1);

    // fill and stall
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h300 + 32'(4*i), 32'(i + 1), 1'b0);
    chk("fill_count", 32'(Count),   32'd4);
    chk("fill_stall", 32'(StallSB), 32'h1);
    cycle(1'b1, 1'b0, 32'h310, 32'd5, 1'b1);
    chk("stall_release_count", 32'(Count), 32'd3);
    cycle(1'b1, 1'b0, 32'h310, 32'd5, 1'b0);
    chk("fifth_accepted", 32'(Count), 32'd4);
    drain_all();

    // forwarding priority
    cycle(1'b1, 1'b0, 32'h200, 32'h11, 1'b0);
    cycle(1'b1, 1'b0, 32'h200, 32'h22, 1'b0);
    cycle(1'b0, 1'b1, 32'h202, 32'h0, 1'b0);
    chk("fwd_hit",  32'(FwdHitM), 32'h1);
    chk("fwd_data", FwdDataM,     32'h22);
    cycle(1'b0, 1'b1, 32'h204, 32'h0, 1'b0);
    chk("fwd_miss", 32'(FwdHitM), 32'h0);
    cycle(1'b1, 1'b1, 32'h200, 32'h33, 1'b0);
    cycle(1'b0, 1'b1, 32'h200, 32'h0, 1'b1);
    chk("fwd_drain_head", FwdDataM, 32'h33);
    drain_all();

    // wrap-around with toggling MemReady
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'(i % 3 == 0), 32'h500 + 32'(4*(i % 5)), $urandom, 1'(i % 2));
    drain_all();

    // simultaneous enqueue and dequeue at Count=2
    cycle(1'b1, 1'b0, 32'h600, 32'hA0, 1'b0);
    cycle(1'b1, 1'b0, 32'h604, 32'hA1, 1'b0);
    cycle(1'b1, 1'b0, 32'h608, 32'hA2, 1'b1);
    chk("simul_count", 32'(Count), 32'd2);
    chk("simul_head",  MemAdr,     32'h604);
    drain_all();

    // random traffic over a small address pool
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom % 2), 1'($urandom % 2),
            32'h400 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3)),
            $urandom, 1'($urandom % 3 != 0));
    drain_all();

    // reset mid-operation with 3 entries buffered
    cycle(1'b1, 1'b0, 32'h700, 32'hB0, 1'b0);
    cycle(1'b1, 1'b0, 32'h704, 32'hB1, 1'b0);
    cycle(1'b1, 1'b0, 32'h708, 32'hB2, 1'b0);
    saved_addr = 32'h704;
    MemWriteM = 1'b0;
    reset = 1'b1;
    #1;
    model_q.delete();
    chk("rst_empty", 32'(Empty),  32'h1);
    chk("rst_memwe", 32'(MemWE),  32'h0);
    chk("rst_count", 32'(Count),  32'h0);
    chk("rst_adr",   MemAdr,      32'h0);
    MemReadM   = 1'b1;
    ALUResultM = saved_addr;
    MemReady   = 1'b1;
    #1;
    chk("rst_fwd_hit",  32'(FwdHitM), 32'h0);
    chk("rst_fwd_data", FwdDataM,     32'h0);
    MemWriteM = 1'b1;
    @(posedge clk); #1;
    chk("rst_held_memwe", 32'(MemWE), 32'h0);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 32'h800, 32'hC0, 1'b0);
    chk("post_rst_store", 32'(Count), 32'd1);
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
